// File: rtl/kex_ram_arbiter.sv
// Single-port KEX weight RAM arbiter: DMA word writes vs. compute burst reads,
// with read data returned one cycle after each issued address.
module kex_ram_arbiter #(
  parameter int N_ELEM = 512,
  parameter int DATA_W = 12,
  parameter int AW     = $clog2(N_ELEM),
  parameter int LW     = $clog2(N_ELEM) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_wr_valid,
  input  logic [AW-1:0]     dma_wr_addr,
  input  logic [DATA_W-1:0] dma_wr_data,
  output logic              dma_wr_ready,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_base,
  input  logic [LW-1:0]     rd_len,
  output logic              rd_ack,
  output logic              rd_busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              rd_done,
  output logic [AW-1:0]     ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic {S_IDLE, S_READ} state_e;
  typedef enum logic {WIN_WRITE, WIN_READ} win_e;

  state_e          state_q, state_d;
  win_e            win_q, win_d;
  logic [AW-1:0]   base_q, base_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            issue_q, issue_d;
  logic            last_q, last_d;
  logic            zdone_q, zdone_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= WIN_READ;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      issue_q <= 1'b0;
      last_q  <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      issue_q <= issue_d;
      last_q  <= last_d;
      zdone_q <= zdone_d;
    end
  end

  // Grants are combinational; gating on rst_n keeps them low while reset is held.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    base_d       = base_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    issue_d      = 1'b0;
    last_d       = 1'b0;
    zdone_d      = 1'b0;
    dma_wr_ready = 1'b0;
    ram_write    = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    rd_ack       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          if (dma_wr_valid && (!rd_req || win_q == WIN_READ)) begin
            dma_wr_ready = 1'b1;
            ram_write    = 1'b1;
            ram_addr     = dma_wr_addr;
            ram_wdata    = dma_wr_data;
            win_d        = WIN_WRITE;
          end else if (rd_req) begin
            rd_ack   = 1'b1;
            ram_addr = rd_base;
            base_d   = rd_base;
            len_d    = rd_len;
            cnt_d    = LW'(1);
            win_d    = WIN_READ;
            issue_d  = (rd_len != '0);
            last_d   = (rd_len == LW'(1));
            zdone_d  = (rd_len == '0);
            if (rd_len > LW'(1)) state_d = S_READ;
          end
        end
        S_READ: begin
          ram_addr = base_q + cnt_q[AW-1:0];
          issue_d  = 1'b1;
          cnt_d    = cnt_q + LW'(1);
          if (cnt_q == len_q - LW'(1)) begin
            last_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rd_valid = issue_q;
  assign rd_last  = last_q;
  assign rd_done  = last_q | zdone_q;
  assign rd_data  = ram_rdata;
  assign rd_busy  = rd_ack | (state_q == S_READ) | issue_q;

endmodule

// File: tb/tb_kex_ram_arbiter.sv
// Directed bench for kex_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_kex_ram_arbiter;
  localparam int N  = 512;
  localparam int DW = 12;
  localparam int AW = 9;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dma_wr_valid = 1'b0;
  logic [AW-1:0] dma_wr_addr = '0;
  logic [DW-1:0] dma_wr_data = '0;
  logic          dma_wr_ready;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_base = '0;
  logic [LW-1:0] rd_len = '0;
  logic          rd_ack, rd_busy, rd_valid, rd_last, rd_done;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_write;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] mem [N];

  int errors = 0;
  int checks = 0;

  kex_ram_arbiter #(.N_ELEM(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dma_wr_valid(dma_wr_valid), .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data),
    .dma_wr_ready(dma_wr_ready),
    .rd_req(rd_req), .rd_base(rd_base), .rd_len(rd_len), .rd_ack(rd_ack), .rd_busy(rd_busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_done(rd_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dma_wr_valid = 1'b0;
    rd_req       = 1'b0;
  endtask

  // flags packed as {ready, write, ack, busy, valid, last, done}
  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rq;
    logic [AW-1:0] rb;
    logic [LW-1:0] rl;
    logic [6:0]    ef;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl [15];
  logic [DW-1:0] beats [$];
  int last_idx;
  int ndone;
  int cnt;

  task automatic do_burst(input logic [AW-1:0] base, input logic [LW-1:0] len);
    beats.delete();
    last_idx = -1;
    ndone    = 0;
    idle_inputs();
    rd_req  = 1'b1;
    rd_base = base;
    rd_len  = len;
    @(negedge clk);
    chk("burst_ack", int'(rd_ack), 1);
    step();
    rd_req = 1'b0;
    for (int c = 0; c < int'(len) + 4; c++) begin
      @(negedge clk);
      if (rd_valid) beats.push_back(rd_data);
      if (rd_last) last_idx = beats.size() - 1;
      if (rd_done) ndone++;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;

    tbl[0]  = '{1'b1, 9'd0, 12'h101, 1'b0, 9'd0, 10'd0, 7'b1100000, 9'd0, 12'h000};
    tbl[1]  = '{1'b1, 9'd1, 12'h102, 1'b0, 9'd0, 10'd0, 7'b1100000, 9'd1, 12'h000};
    tbl[2]  = '{1'b1, 9'd2, 12'h103, 1'b0, 9'd0, 10'd0, 7'b1100000, 9'd2, 12'h000};
    tbl[3]  = '{1'b1, 9'd3, 12'h104, 1'b0, 9'd0, 10'd0, 7'b1100000, 9'd3, 12'h000};
    tbl[4]  = '{1'b0, 9'd0, 12'h000, 1'b1, 9'd0, 10'd4, 7'b0011000, 9'd0, 12'h000};
    tbl[5]  = '{1'b0, 9'd0, 12'h000, 1'b0, 9'd0, 10'd0, 7'b0001100, 9'd1, 12'h101};
    tbl[6]  = '{1'b0, 9'd0, 12'h000, 1'b0, 9'd0, 10'd0, 7'b0001100, 9'd2, 12'h102};
    tbl[7]  = '{1'b0, 9'd0, 12'h000, 1'b0, 9'd0, 10'd0, 7'b0001100, 9'd3, 12'h103};
    tbl[8]  = '{1'b0, 9'd0, 12'h000, 1'b0, 9'd0, 10'd0, 7'b0001111, 9'd0, 12'h104};
    tbl[9]  = '{1'b1, 9'd5, 12'h1AA, 1'b1, 9'd5, 10'd1, 7'b1100000, 9'd5, 12'h000};
    tbl[10] = '{1'b1, 9'd6, 12'h1BB, 1'b1, 9'd5, 10'd1, 7'b0011000, 9'd5, 12'h000};
    tbl[11] = '{1'b1, 9'd6, 12'h1BB, 1'b0, 9'd0, 10'd0, 7'b1101111, 9'd6, 12'h1AA};
    tbl[12] = '{1'b0, 9'd0, 12'h000, 1'b1, 9'd0, 10'd0, 7'b0011000, 9'd0, 12'h000};
    tbl[13] = '{1'b1, 9'd7, 12'h1CC, 1'b0, 9'd0, 10'd0, 7'b1100001, 9'd7, 12'h000};
    tbl[14] = '{1'b0, 9'd0, 12'h000, 1'b0, 9'd0, 10'd0, 7'b0000000, 9'd0, 12'h000};

    // Reset state
    dma_wr_valid = 1'b1;
    rd_req       = 1'b1;
    #12;
    chk("reset_flags", {dma_wr_ready, ram_write, rd_ack, rd_busy, rd_valid, rd_last, rd_done}, 0);
    chk("reset_addr", int'(ram_addr), 0);
    idle_inputs();
    step();
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      dma_wr_valid = tbl[i].wv;
      dma_wr_addr  = tbl[i].wa;
      dma_wr_data  = tbl[i].wd;
      rd_req       = tbl[i].rq;
      rd_base      = tbl[i].rb;
      rd_len       = tbl[i].rl;
      @(negedge clk);
      chk($sformatf("v%0d_flags", i),
          {dma_wr_ready, ram_write, rd_ack, rd_busy, rd_valid, rd_last, rd_done}, tbl[i].ef);
      chk($sformatf("v%0d_addr", i), int'(ram_addr), int'(tbl[i].ea));
      chk($sformatf("v%0d_wdata", i), int'(ram_wdata), tbl[i].ef[5] ? int'(tbl[i].wd) : 0);
      if (tbl[i].ef[2]) chk($sformatf("v%0d_rdata", i), int'(rd_data), int'(tbl[i].ed));
      step();
    end
    idle_inputs();

    // Fill every word with its own address
    cnt = 0;
    for (int a = 0; a < N; a++) begin
      dma_wr_valid = 1'b1;
      dma_wr_addr  = AW'(a);
      dma_wr_data  = DW'(a);
      @(negedge clk);
      if (dma_wr_ready && ram_write) cnt++;
      step();
    end
    idle_inputs();
    chk("fill_ready_cycles", cnt, N);

    // Wrap past the top of the RAM
    do_burst(9'(N - 2), 10'd4);
    chk("wrap_nbeats", beats.size(), 4);
    if (beats.size() == 4) begin
      chk("wrap_b0", int'(beats[0]), N - 2);
      chk("wrap_b1", int'(beats[1]), N - 1);
      chk("wrap_b2", int'(beats[2]), 0);
      chk("wrap_b3", int'(beats[3]), 1);
    end
    chk("wrap_last_idx", last_idx, 3);
    chk("wrap_done", ndone, 1);

    // Full-RAM burst
    do_burst(9'd5, 10'(N));
    chk("full_nbeats", beats.size(), N);
    if (beats.size() == N) begin
      chk("full_first", int'(beats[0]), 5);
      chk("full_wrap", int'(beats[N - 5]), 0);
      chk("full_final", int'(beats[N - 1]), 4);
    end
    chk("full_last_idx", last_idx, N - 1);
    chk("full_done", ndone, 1);

    // Reset in the middle of a len=8 burst
    rd_req  = 1'b1;
    rd_base = 9'd0;
    rd_len  = 10'd8;
    @(negedge clk);
    chk("abort_ack", int'(rd_ack), 1);
    step();
    rd_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {dma_wr_ready, ram_write, rd_ack, rd_busy, rd_valid, rd_last, rd_done}, 0);
    chk("abort_addr", int'(ram_addr), 0);
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rd_valid || rd_done || rd_busy) cnt++;
      step();
    end
    chk("abort_quiet", cnt, 0);
    do_burst(9'd0, 10'd2);
    chk("post_nbeats", beats.size(), 2);
    if (beats.size() == 2) begin
      chk("post_b0", int'(beats[0]), 0);
      chk("post_b1", int'(beats[1]), 1);
    end
    chk("post_done", ndone, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
